parity_serializer: RTL and testbench

Upstream feeder for the serial odd/even parity tracker. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, on a single serial line. It can append a generated parity bit and marks frame boundaries, so the downstream tracker sees a continuous bit stream with known word alignment.

---
 rtl/parity_serializer.sv | 93 +++++++++
 tb/tb_parity_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/parity_serializer.sv
// Parallel-to-serial feeder: shifts a word out LSB-first with an optional
// appended parity bit and frame_start/frame_end markers.
module parity_serializer #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             par, par_d;
    logic             last_bit, accept;
    logic             x_d, xv_d, fs_d, fe_d;

    always_comb begin
        // The frame_end cycle doubles as the accept slot for the next word.
        last_bit  = (state == PAR) || (state == SHIFT && cnt == LAST && !PARITY_EN);
        din_ready = (state == IDLE) || last_bit;
        accept    = din_valid && din_ready;

        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        par_d   = par;

        case (state)
            IDLE: ;
            SHIFT: begin
                if (cnt != LAST) begin
                    shreg_d = shreg >> 1;
                    cnt_d   = cnt + CW'(1);
                end else if (PARITY_EN) begin
                    state_d = PAR;
                end else begin
                    state_d = IDLE;
                end
            end
            PAR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SHIFT;
            shreg_d = din;
            cnt_d   = '0;
            par_d   = (^din) ^ ODD_PARITY;
        end

        // Outputs are decoded from the next state so they register cleanly.
        xv_d = (state_d != IDLE);
        x_d  = (state_d == SHIFT) ? shreg_d[0] :
               (state_d == PAR)   ? par_d      : 1'b0;
        fs_d = (state_d == SHIFT) && (cnt_d == '0);
        fe_d = (state_d == PAR) || (!PARITY_EN && state_d == SHIFT && cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            par         <= 1'b0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            cnt         <= cnt_d;
            par         <= par_d;
            x           <= x_d;
            x_valid     <= xv_d;
            frame_start <= fs_d;
            frame_end   <= fe_d;
        end
    end
endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: three configurations checked against a
// frame-queue reference model plus hand-computed vector tables.
module tb_parity_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] din [3];
    logic        dv  [3];
    logic        rdy [3], xo [3], xv [3], fso [3], feo [3];

    // 0: 8-bit even parity, 1: 8-bit odd parity, 2: 4-bit no parity
    parity_serializer #(.WIDTH(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b0)) u0 (
        .clk(clk), .rst(rst), .din(din[0][7:0]), .din_valid(dv[0]), .din_ready(rdy[0]),
        .x(xo[0]), .x_valid(xv[0]), .frame_start(fso[0]), .frame_end(feo[0]));
    parity_serializer #(.WIDTH(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b1)) u1 (
        .clk(clk), .rst(rst), .din(din[1][7:0]), .din_valid(dv[1]), .din_ready(rdy[1]),
        .x(xo[1]), .x_valid(xv[1]), .frame_start(fso[1]), .frame_end(feo[1]));
    parity_serializer #(.WIDTH(4), .PARITY_EN(1'b0), .ODD_PARITY(1'b0)) u2 (
        .clk(clk), .rst(rst), .din(din[2][3:0]), .din_valid(dv[2]), .din_ready(rdy[2]),
        .x(xo[2]), .x_valid(xv[2]), .frame_start(fso[2]), .frame_end(feo[2]));

    function automatic int wof(int i);  return (i == 2) ? 4 : 8; endfunction
    function automatic bit pe(int i);   return (i != 2);        endfunction
    function automatic bit od(int i);   return (i == 1);        endfunction

    typedef struct packed {logic v; logic x; logic fs; logic fe;} bit_t;
    bit_t q [3][$];
    bit_t cur [3];
    int nvec = 0;
    int nerr = 0;

    function automatic logic exp_rdy(int i);
        return !cur[i].v || cur[i].fe;
    endfunction

    // A frame is just the list of bits it will put on the line.
    task automatic push_frame(int i, logic [31:0] d);
        bit_t e;
        logic p;
        p = od(i);
        for (int b = 0; b < wof(i); b++) begin
            e.v = 1'b1; e.x = d[b]; e.fs = (b == 0); e.fe = !pe(i) && (b == wof(i) - 1);
            q[i].push_back(e);
            p ^= d[b];
        end
        if (pe(i)) begin
            e.v = 1'b1; e.x = p; e.fs = 1'b0; e.fe = 1'b1;
            q[i].push_back(e);
        end
    endtask

    task automatic check_model(string tag);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if ({xo[i], xv[i], fso[i], feo[i], rdy[i]} !==
                {cur[i].x, cur[i].v, cur[i].fs, cur[i].fe, exp_rdy(i)}) begin
                nerr++;
                $display("FAIL %s inst%0d t=%0t got x/v/fs/fe/rdy=%b%b%b%b%b want %b%b%b%b%b",
                         tag, i, $time, xo[i], xv[i], fso[i], feo[i], rdy[i],
                         cur[i].x, cur[i].v, cur[i].fs, cur[i].fe, exp_rdy(i));
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
                cur[i] = '0;
            end else begin
                if (dv[i] && exp_rdy(i)) push_frame(i, din[i]);
                cur[i] = (q[i].size() > 0) ? q[i].pop_front() : bit_t'(0);
            end
        end
        @(negedge clk);
        check_model("model");
    endtask

    typedef struct {int inst; logic [31:0] d; logic [31:0] bits; int len;} vec_t;
    vec_t tbl [8];

    task automatic run_vec(vec_t v);
        int i;
        i = v.inst;
        din[i] = v.d;
        dv[i]  = 1'b1;
        tick();
        dv[i]  = 1'b0;
        for (int k = 0; k < v.len; k++) begin
            chk($sformatf("tbl_x i%0d d%0h k%0d", i, v.d, k), 32'(xo[i]), 32'(v.bits[k]));
            chk($sformatf("tbl_flags i%0d d%0h k%0d", i, v.d, k),
                {28'd0, xv[i], fso[i], feo[i], rdy[i]},
                {28'd0, 1'b1, (k == 0), (k == v.len - 1), (k == v.len - 1)});
            tick();
        end
        chk($sformatf("tbl_idle i%0d d%0h", i, v.d), 32'(xv[i]), 32'd0);
    endtask

    initial begin
        int cntv;
        logic [17:0] seq;
        // bits are LSB-first: data then parity at bit WIDTH
        tbl[0] = '{0, 32'hA5, 32'h0A5, 9};
        tbl[1] = '{1, 32'h07, 32'h007, 9};
        tbl[2] = '{1, 32'h03, 32'h103, 9};
        tbl[3] = '{2, 32'hC,  32'hC,   4};
        tbl[4] = '{0, 32'hFF, 32'h0FF, 9};
        tbl[5] = '{1, 32'h00, 32'h100, 9};
        tbl[6] = '{2, 32'h5,  32'h5,   4};
        tbl[7] = '{0, 32'h81, 32'h081, 9};

        for (int i = 0; i < 3; i++) begin
            din[i] = '0; dv[i] = 1'b0; cur[i] = '0;
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_ready", {29'd0, rdy[0], rdy[1], rdy[2]}, 32'h7);

        for (int t = 0; t < 8; t++) run_vec(tbl[t]);

        // back-to-back FF then 00 with din_valid held high
        din[0] = 32'hFF; dv[0] = 1'b1;
        tick();
        din[0] = 32'h00;
        cntv = 0;
        for (int k = 0; k < 18; k++) begin
            seq[k] = xo[0];
            if (xv[0]) cntv++;
            tick();
            if (k == 8) dv[0] = 1'b0;
        end
        chk("b2b_bits", 32'(seq), 32'h000FF);
        chk("b2b_valid_run", cntv, 18);
        chk("b2b_idle_after", 32'(xv[0]), 32'd0);

        // reset asserted while data bit 3 of 5A is on the line
        din[0] = 32'h5A; dv[0] = 1'b1;
        tick();
        dv[0] = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_bit3", {30'd0, xv[0], xo[0]}, 32'h3);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            cur[i] = '0;
        end
        check_model("async_rst");
        tick();
        rst = 1'b0;
        tick();
        run_vec(tbl[7]);

        // din_valid pulse while busy must not capture a word
        din[0] = 32'hA5; dv[0] = 1'b1;
        tick();
        dv[0] = 1'b0;
        cntv = 1;
        tick(); tick();
        cntv += 2;
        din[0] = 32'h3C; dv[0] = 1'b1;
        tick();
        if (xv[0]) cntv++;
        dv[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (xv[0]) cntv++;
        end
        chk("busy_pulse_len", cntv, 9);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                dv[i]  = ($urandom_range(0, 2) != 0);
                din[i] = $urandom;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        for (int k = 0; k < 12; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
